// File: rtl/ysyx_23060025_axi_rr_arbiter_pkg.sv
// Shared FSM encodings and AXI constants for the round-robin AXI arbiter.
package ysyx_23060025_axi_rr_arbiter_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_e;

  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060025_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module ysyx_23060025_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0] j;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (j >= (IDX_W + 1)'(NUM_REQ)) j = j - (IDX_W + 1)'(NUM_REQ);
      if (req[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ysyx_23060025_axi_rr_arbiter.sv
// N-requester AXI4 arbiter, independent round-robin read/write, one transaction per direction.
// Define AXI_ARB_IDCHK_EN to force SLVERR when the returned rid/bid differs from the grant.
module ysyx_23060025_axi_rr_arbiter
  import ysyx_23060025_axi_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ID_W     = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_ar_valid_i,
  output logic [NUM_REQ-1:0]               req_ar_ready_o,
  input  logic [NUM_REQ*ADDR_LEN-1:0]      req_ar_addr_i,
  input  logic [NUM_REQ*8-1:0]             req_ar_len_i,
  input  logic [NUM_REQ*3-1:0]             req_ar_size_i,
  output logic [NUM_REQ-1:0]               req_r_valid_o,
  input  logic [NUM_REQ-1:0]               req_r_ready_i,
  output logic [DATA_LEN-1:0]              req_r_data_o,
  output logic [1:0]                       req_r_resp_o,
  output logic                             req_r_last_o,
  input  logic [NUM_REQ-1:0]               req_aw_valid_i,
  output logic [NUM_REQ-1:0]               req_aw_ready_o,
  input  logic [NUM_REQ*ADDR_LEN-1:0]      req_aw_addr_i,
  input  logic [NUM_REQ*8-1:0]             req_aw_len_i,
  input  logic [NUM_REQ*3-1:0]             req_aw_size_i,
  input  logic [NUM_REQ-1:0]               req_w_valid_i,
  output logic [NUM_REQ-1:0]               req_w_ready_o,
  input  logic [NUM_REQ*DATA_LEN-1:0]      req_w_data_i,
  input  logic [NUM_REQ*(DATA_LEN/8)-1:0]  req_w_strb_i,
  input  logic [NUM_REQ-1:0]               req_w_last_i,
  output logic [NUM_REQ-1:0]               req_b_valid_o,
  input  logic [NUM_REQ-1:0]               req_b_ready_i,
  output logic [1:0]                       req_b_resp_o,
  // Downstream AXI4 master
  input  logic                             m_arready,
  output logic                             m_arvalid,
  output logic [ADDR_LEN-1:0]              m_araddr,
  output logic [ID_W-1:0]                  m_arid,
  output logic [7:0]                       m_arlen,
  output logic [2:0]                       m_arsize,
  output logic [1:0]                       m_arburst,
  output logic                             m_rready,
  input  logic                             m_rvalid,
  input  logic [1:0]                       m_rresp,
  input  logic [DATA_LEN-1:0]              m_rdata,
  input  logic                             m_rlast,
  input  logic [ID_W-1:0]                  m_rid,
  input  logic                             m_awready,
  output logic                             m_awvalid,
  output logic [ADDR_LEN-1:0]              m_awaddr,
  output logic [ID_W-1:0]                  m_awid,
  output logic [7:0]                       m_awlen,
  output logic [2:0]                       m_awsize,
  output logic [1:0]                       m_awburst,
  input  logic                             m_wready,
  output logic                             m_wvalid,
  output logic [DATA_LEN-1:0]              m_wdata,
  output logic [DATA_LEN/8-1:0]            m_wstrb,
  output logic                             m_wlast,
  output logic                             m_bready,
  input  logic                             m_bvalid,
  input  logic [1:0]                       m_bresp,
  input  logic [ID_W-1:0]                  m_bid
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned STRB_W = DATA_LEN / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [ADDR_LEN-1:0] ar_addr_a [NUM_REQ];
  logic [7:0]          ar_len_a  [NUM_REQ];
  logic [2:0]          ar_size_a [NUM_REQ];
  logic [ADDR_LEN-1:0] aw_addr_a [NUM_REQ];
  logic [7:0]          aw_len_a  [NUM_REQ];
  logic [2:0]          aw_size_a [NUM_REQ];
  logic [DATA_LEN-1:0] w_data_a  [NUM_REQ];
  logic [STRB_W-1:0]   w_strb_a  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign ar_addr_a[k] = req_ar_addr_i[k*ADDR_LEN +: ADDR_LEN];
    assign ar_len_a[k]  = req_ar_len_i[k*8 +: 8];
    assign ar_size_a[k] = req_ar_size_i[k*3 +: 3];
    assign aw_addr_a[k] = req_aw_addr_i[k*ADDR_LEN +: ADDR_LEN];
    assign aw_len_a[k]  = req_aw_len_i[k*8 +: 8];
    assign aw_size_a[k] = req_aw_size_i[k*3 +: 3];
    assign w_data_a[k]  = req_w_data_i[k*DATA_LEN +: DATA_LEN];
    assign w_strb_a[k]  = req_w_strb_i[k*STRB_W +: STRB_W];
  end

  // ---------------- read direction ----------------
  rd_state_e           rd_state;
  logic [IDX_W-1:0]    rr_rd, g_rd, rd_idx;
  logic                rd_found;
  logic [ADDR_LEN-1:0] ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;

  ysyx_23060025_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_rd (
    .req   (req_ar_valid_i),
    .ptr   (rr_rd),
    .found (rd_found),
    .idx   (rd_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rr_rd    <= '0;
      g_rd     <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: if (rd_found) begin
          g_rd     <= rd_idx;
          ar_addr  <= ar_addr_a[rd_idx];
          ar_len   <= ar_len_a[rd_idx];
          ar_size  <= ar_size_a[rd_idx];
          rr_rd    <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
          rd_state <= RD_ADDR;
        end
        RD_ADDR: if (m_arready) rd_state <= RD_DATA;
        RD_DATA: if (m_rvalid && m_rready && m_rlast) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  logic [NUM_REQ-1:0] g_rd_oh, rd_idx_oh;
  assign g_rd_oh   = NUM_REQ'(1) << g_rd;
  assign rd_idx_oh = NUM_REQ'(1) << rd_idx;

  assign req_ar_ready_o = (!reset && rd_state == RD_IDLE && rd_found) ? rd_idx_oh : '0;
  assign m_arvalid      = (rd_state == RD_ADDR);
  assign m_araddr       = ar_addr;
  assign m_arid         = ID_W'(g_rd);
  assign m_arlen        = ar_len;
  assign m_arsize       = ar_size;
  assign m_arburst      = INCR;
  assign m_rready       = (rd_state == RD_DATA) && req_r_ready_i[g_rd];
  assign req_r_valid_o  = (rd_state == RD_DATA && m_rvalid) ? g_rd_oh : '0;
  assign req_r_data_o   = m_rdata;
  assign req_r_last_o   = m_rlast;

  // ---------------- write direction ----------------
  wr_state_e           wr_state;
  logic [IDX_W-1:0]    rr_wr, g_wr, wr_idx;
  logic                wr_found, aw_done, w_done;
  logic [ADDR_LEN-1:0] aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic                aw_hs, w_last_hs;

  ysyx_23060025_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_wr (
    .req   (req_aw_valid_i),
    .ptr   (rr_wr),
    .found (wr_found),
    .idx   (wr_idx)
  );

  assign aw_hs     = m_awvalid && m_awready;
  assign w_last_hs = m_wvalid && m_wready && m_wlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      rr_wr    <= '0;
      g_wr     <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      unique case (wr_state)
        WR_IDLE: if (wr_found) begin
          g_wr     <= wr_idx;
          aw_addr  <= aw_addr_a[wr_idx];
          aw_len   <= aw_len_a[wr_idx];
          aw_size  <= aw_size_a[wr_idx];
          rr_wr    <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
          wr_state <= WR_XFER;
        end
        WR_XFER: begin
          if (aw_hs)     aw_done <= 1'b1;
          if (w_last_hs) w_done  <= 1'b1;
          // AW and the last W beat may complete in either order or together.
          if ((aw_done || aw_hs) && (w_done || w_last_hs)) wr_state <= WR_RESP;
        end
        WR_RESP: if (m_bvalid && m_bready) begin
          wr_state <= WR_IDLE;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  logic [NUM_REQ-1:0] g_wr_oh, wr_idx_oh;
  assign g_wr_oh   = NUM_REQ'(1) << g_wr;
  assign wr_idx_oh = NUM_REQ'(1) << wr_idx;

  assign req_aw_ready_o = (!reset && wr_state == WR_IDLE && wr_found) ? wr_idx_oh : '0;
  assign m_awvalid      = (wr_state == WR_XFER) && !aw_done;
  assign m_awaddr       = aw_addr;
  assign m_awid         = ID_W'(g_wr);
  assign m_awlen        = aw_len;
  assign m_awsize       = aw_size;
  assign m_awburst      = INCR;
  assign m_wvalid       = (wr_state == WR_XFER) && req_w_valid_i[g_wr] && !w_done;
  assign m_wdata        = w_data_a[g_wr];
  assign m_wstrb        = w_strb_a[g_wr];
  assign m_wlast        = req_w_last_i[g_wr];
  assign req_w_ready_o  = (wr_state == WR_XFER && m_wready && !w_done) ? g_wr_oh : '0;
  assign m_bready       = (wr_state == WR_RESP) && req_b_ready_i[g_wr];
  assign req_b_valid_o  = (wr_state == WR_RESP && m_bvalid) ? g_wr_oh : '0;

`ifdef AXI_ARB_IDCHK_EN
  assign req_r_resp_o = (m_rid != ID_W'(g_rd)) ? SLVERR : m_rresp;
  assign req_b_resp_o = (m_bid != ID_W'(g_wr)) ? SLVERR : m_bresp;
`else
  logic unused_ids;
  assign unused_ids   = ^{m_rid, m_bid};
  assign req_r_resp_o = m_rresp;
  assign req_b_resp_o = m_bresp;
`endif

endmodule

// File: tb/tb_ysyx_23060025_axi_rr_arbiter.sv
// Directed self-checking bench for ysyx_23060025_axi_rr_arbiter (NUM_REQ=3, 32-bit, ID_W=4).
module tb_ysyx_23060025_axi_rr_arbiter;

  localparam int N = 3;

  logic          clock, reset;
  logic [N-1:0]  req_ar_valid_i, req_ar_ready_o;
  logic [N*32-1:0] req_ar_addr_i;
  logic [N*8-1:0]  req_ar_len_i;
  logic [N*3-1:0]  req_ar_size_i;
  logic [N-1:0]  req_r_valid_o, req_r_ready_i;
  logic [31:0]   req_r_data_o;
  logic [1:0]    req_r_resp_o;
  logic          req_r_last_o;
  logic [N-1:0]  req_aw_valid_i, req_aw_ready_o;
  logic [N*32-1:0] req_aw_addr_i;
  logic [N*8-1:0]  req_aw_len_i;
  logic [N*3-1:0]  req_aw_size_i;
  logic [N-1:0]  req_w_valid_i, req_w_ready_o;
  logic [N*32-1:0] req_w_data_i;
  logic [N*4-1:0]  req_w_strb_i;
  logic [N-1:0]  req_w_last_i, req_b_valid_o, req_b_ready_i;
  logic [1:0]    req_b_resp_o;
  logic          m_arready, m_arvalid;
  logic [31:0]   m_araddr;
  logic [3:0]    m_arid;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_rready, m_rvalid;
  logic [1:0]    m_rresp;
  logic [31:0]   m_rdata;
  logic          m_rlast;
  logic [3:0]    m_rid;
  logic          m_awready, m_awvalid;
  logic [31:0]   m_awaddr;
  logic [3:0]    m_awid;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_wready, m_wvalid;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wlast, m_bready, m_bvalid;
  logic [1:0]    m_bresp;
  logic [3:0]    m_bid;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_resp;

  ysyx_23060025_axi_rr_arbiter #(.NUM_REQ(N), .ADDR_LEN(32), .DATA_LEN(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_ar_valid_i(req_ar_valid_i), .req_ar_ready_o(req_ar_ready_o),
    .req_ar_addr_i(req_ar_addr_i), .req_ar_len_i(req_ar_len_i), .req_ar_size_i(req_ar_size_i),
    .req_r_valid_o(req_r_valid_o), .req_r_ready_i(req_r_ready_i),
    .req_r_data_o(req_r_data_o), .req_r_resp_o(req_r_resp_o), .req_r_last_o(req_r_last_o),
    .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o),
    .req_aw_addr_i(req_aw_addr_i), .req_aw_len_i(req_aw_len_i), .req_aw_size_i(req_aw_size_i),
    .req_w_valid_i(req_w_valid_i), .req_w_ready_o(req_w_ready_o),
    .req_w_data_i(req_w_data_i), .req_w_strb_i(req_w_strb_i), .req_w_last_i(req_w_last_i),
    .req_b_valid_o(req_b_valid_o), .req_b_ready_i(req_b_ready_i), .req_b_resp_o(req_b_resp_o),
    .m_arready(m_arready), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rready(m_rready), .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awready(m_awready), .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wready(m_wready), .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bready(m_bready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One single-beat read; requester g is expected to win the current idle cycle.
  task automatic rd_single(input int g, input logic [31:0] addr);
    #1;
    check("t1_ar_ready", 64'(req_ar_ready_o), 64'(1 << g));
    tick();
    check("t1_arvalid", 64'(m_arvalid), 64'd1);
    check("t1_arid", 64'(m_arid), 64'(g));
    check("t1_araddr", 64'(m_araddr), 64'(addr));
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hD0 + 32'(g);
    #1;
    check("t1_r_valid", 64'(req_r_valid_o), 64'(1 << g));
    check("t1_r_data", 64'(req_r_data_o), 64'(32'hD0 + 32'(g)));
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_ar_valid_i = '0; req_ar_addr_i = '0; req_ar_len_i = '0; req_ar_size_i = '0;
    req_r_ready_i = '1;
    req_aw_valid_i = '0; req_aw_addr_i = '0; req_aw_len_i = '0; req_aw_size_i = '0;
    req_w_valid_i = '0; req_w_data_i = '0; req_w_strb_i = '0; req_w_last_i = '0;
    req_b_ready_i = '1;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0; m_rlast = 0; m_rid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
    tick(); tick();
    check("rst_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_awvalid", 64'(m_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_wvalid), 64'd0);
    check("rst_r_valid", 64'(req_r_valid_o), 64'd0);
    check("rst_arburst", 64'(m_arburst), 64'd1);
    check("rst_awburst", 64'(m_awburst), 64'd1);
    reset = 1'b0;

    // 1: all three read continuously -> grants 0,1,2,0
    req_ar_addr_i = {32'h2000_0000, 32'h1000_0000, 32'h0000_1000};
    req_ar_valid_i = 3'b111;
    rd_single(0, 32'h0000_1000);
    rd_single(1, 32'h1000_0000);
    rd_single(2, 32'h2000_0000);
    rd_single(0, 32'h0000_1000);
    req_ar_valid_i = '0;

    // 2: requester 1, 4-beat burst at 0x8000_0000; rr_rd is 1 here
    req_ar_addr_i[32 +: 32] = 32'h8000_0000;
    req_ar_len_i[8 +: 8] = 8'd3;
    req_ar_size_i[3 +: 3] = 3'd2;
    req_ar_valid_i = 3'b010;
    #1;
    check("t2_ar_ready", 64'(req_ar_ready_o), 64'b010);
    tick();
    req_ar_valid_i = '0;
    check("t2_arlen", 64'(m_arlen), 64'd3);
    check("t2_arsize", 64'(m_arsize), 64'd2);
    check("t2_araddr", 64'(m_araddr), 64'h8000_0000);
    tick();
    check("t2_arvalid_held", 64'(m_arvalid), 64'd1);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    req_r_ready_i = 3'b101;
    m_rvalid = 1'b1;
    #1;
    check("t2_rready_bp", 64'(m_rready), 64'd0);
    req_r_ready_i = 3'b111;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'h100 + 32'(b); m_rlast = (b == 3);
      #1;
      check("t2_r_valid", 64'(req_r_valid_o), 64'b010);
      check("t2_r_data", 64'(req_r_data_o), 64'(32'h100 + 32'(b)));
      check("t2_r_last", 64'(req_r_last_o), 64'(b == 3));
      tick();
    end
    m_rlast = 1'b0;
    #1;
    check("t2_idle_no_r", 64'(req_r_valid_o), 64'd0);
    m_rvalid = 1'b0;

    // len=255 from requester 2 (rr_rd=2)
    req_ar_len_i[16 +: 8] = 8'd255;
    req_ar_valid_i = 3'b100;
    tick();
    req_ar_valid_i = '0;
    check("t2_arlen255", 64'(m_arlen), 64'd255);
    check("t2_arid2", 64'(m_arid), 64'd2);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // 3a: write from requester 0, AW three cycles before W
    req_aw_addr_i[0 +: 32] = 32'h3000_0000;
    req_aw_valid_i = 3'b001;
    #1;
    check("t3a_aw_ready", 64'(req_aw_ready_o), 64'b001);
    tick();
    req_aw_valid_i = '0;
    check("t3a_awvalid", 64'(m_awvalid), 64'd1);
    check("t3a_awaddr", 64'(m_awaddr), 64'h3000_0000);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    check("t3a_aw_done", 64'(m_awvalid), 64'd0);
    tick(); tick();
    check("t3a_no_w", 64'(m_wvalid), 64'd0);
    req_w_data_i[0 +: 32] = 32'hCAFE_0000; req_w_strb_i[0 +: 4] = 4'hF;
    req_w_valid_i = 3'b001; req_w_last_i = 3'b001; m_wready = 1'b1;
    #1;
    check("t3a_wvalid", 64'(m_wvalid), 64'd1);
    check("t3a_wdata", 64'(m_wdata), 64'hCAFE_0000);
    check("t3a_w_ready", 64'(req_w_ready_o), 64'b001);
    tick();
    req_w_valid_i = '0; req_w_last_i = '0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    check("t3a_b_valid", 64'(req_b_valid_o), 64'b001);
    check("t3a_bready", 64'(m_bready), 64'd1);
    tick();
    check("t3a_single_b", 64'(req_b_valid_o), 64'd0);
    m_bvalid = 1'b0;

    // 3b: write from requester 1, W completes before AW
    req_aw_addr_i[32 +: 32] = 32'h3000_0100;
    req_aw_valid_i = 3'b010;
    #1;
    check("t3b_aw_ready", 64'(req_aw_ready_o), 64'b010);
    tick();
    req_aw_valid_i = '0;
    req_w_data_i[32 +: 32] = 32'hBEEF_0001; req_w_strb_i[4 +: 4] = 4'h3;
    req_w_valid_i = 3'b010; req_w_last_i = 3'b010; m_wready = 1'b1;
    #1;
    check("t3b_w_ready", 64'(req_w_ready_o), 64'b010);
    check("t3b_wstrb", 64'(m_wstrb), 64'h3);
    tick();
    check("t3b_w_done", 64'(m_wvalid), 64'd0);
    check("t3b_w_ready_off", 64'(req_w_ready_o), 64'd0);
    req_w_valid_i = '0; req_w_last_i = '0; m_wready = 1'b0;
    check("t3b_awvalid", 64'(m_awvalid), 64'd1);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b11;
    #1;
    check("t3b_b_valid", 64'(req_b_valid_o), 64'b010);
    check("t3b_b_resp", 64'(req_b_resp_o), 64'b11);
    tick();
    check("t3b_single_b", 64'(req_b_valid_o), 64'd0);
    m_bvalid = 1'b0; m_bresp = 2'b00;

    // 4: concurrent read (req 0) and write (req 2)
    req_ar_valid_i = 3'b001; req_aw_valid_i = 3'b100;
    #1;
    check("t4_ar_ready", 64'(req_ar_ready_o), 64'b001);
    check("t4_aw_ready", 64'(req_aw_ready_o), 64'b100);
    tick();
    req_ar_valid_i = '0; req_aw_valid_i = '0;
    check("t4_both_valid", 64'({m_arvalid, m_awvalid}), 64'b11);
    check("t4_ids", 64'({m_arid, m_awid}), 64'h02);
    m_arready = 1'b1; m_awready = 1'b1;
    req_w_valid_i = 3'b100; req_w_last_i = 3'b100; m_wready = 1'b1;
    tick();
    m_arready = 1'b0; m_awready = 1'b0;
    req_w_valid_i = '0; req_w_last_i = '0; m_wready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_bvalid = 1'b1;
    #1;
    check("t4_r_valid", 64'(req_r_valid_o), 64'b001);
    check("t4_b_valid", 64'(req_b_valid_o), 64'b100);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;

    // 5: reset during beat 2 of 4 (req 1, rr_rd=1 -> would become 2)
    req_ar_valid_i = 3'b010;
    tick();
    req_ar_valid_i = '0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("t5_beat2_fwd", 64'(req_r_valid_o), 64'b010);
    tick();
    reset = 1'b0;
    req_ar_valid_i = 3'b110;
    #1;
    check("t5_r_valid_off", 64'(req_r_valid_o), 64'd0);
    check("t5_rready_off", 64'(m_rready), 64'd0);
    check("t5_arvalid_off", 64'(m_arvalid), 64'd0);
    check("t5_rr_reset", 64'(req_ar_ready_o), 64'b010);
    m_rvalid = 1'b0;
    tick();
    req_ar_valid_i = '0;
    check("t5_regrant_id", 64'(m_arid), 64'd1);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;

    // 6: rid mismatch (rid=3, grant=1)
`ifdef AXI_ARB_IDCHK_EN
    exp_resp = 2'b10;
`else
    exp_resp = 2'b00;
`endif
    m_rvalid = 1'b1; m_rid = 4'd3; m_rresp = 2'b00; m_rdata = 32'h5A5A_0006;
    #1;
    check("t6_resp_mismatch", 64'(req_r_resp_o), 64'(exp_resp));
    check("t6_data", 64'(req_r_data_o), 64'h5A5A_0006);
    m_rid = 4'd1;
    #1;
    check("t6_resp_match", 64'(req_r_resp_o), 64'd0);
    m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("t6_idle", 64'(m_arvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_axi_rr_arbiter.md
Name: ysyx_23060025_axi_rr_arbiter

Overview:
Parametrised N-requester AXI4 arbiter that merges NUM_REQ internal masters (IFU, LSU, future DMA/debug) onto one downstream AXI4 master port, in front of the xbar.
- Read and write directions are arbitrated independently, round-robin, one outstanding transaction per direction.
- Bursts are passed through.
- Generalises the fixed two-master (inst/data) controller to any requester count, with burst support and fairness.

Parameters:
NUM_REQ, 3, number of requesters (>=2); localparam IDX_W = $clog2(NUM_REQ).
ADDR_LEN, 32, address width.
DATA_LEN, 32, data width.
ID_W, 4, downstream AXI ID width; must satisfy ID_W >= IDX_W.

Ports:
Per-requester ports are flattened vectors; requester k occupies slice k.
clock  in  1  clock.
reset  in  1  synchronous, active-high reset.
req_ar_valid_i  in  NUM_REQ  read address valid.
req_ar_ready_o  out  NUM_REQ  read address accepted.
req_ar_addr_i  in  NUM_REQ*ADDR_LEN  read address.
req_ar_len_i  in  NUM_REQ*8  read burst length.
req_ar_size_i  in  NUM_REQ*3  read beat size.
req_r_valid_o  out  NUM_REQ  read data valid.
req_r_ready_i  in  NUM_REQ  read data ready.
req_r_data_o  out  DATA_LEN  read data, shared by all requesters.
req_r_resp_o  out  2  read response, shared.
req_r_last_o  out  1  last read beat, shared.
req_aw_valid_i / req_aw_ready_o / req_aw_addr_i / req_aw_len_i / req_aw_size_i  same shapes as the AR group.
req_w_valid_i  in  NUM_REQ  write data valid.
req_w_ready_o  out  NUM_REQ  write data accepted.
req_w_data_i  in  NUM_REQ*DATA_LEN  write data.
req_w_strb_i  in  NUM_REQ*(DATA_LEN/8)  write strobes.
req_w_last_i  in  NUM_REQ  last write beat.
req_b_valid_o  out  NUM_REQ  write response valid.
req_b_ready_i  in  NUM_REQ  write response ready.
req_b_resp_o  out  2  write response, shared.
m_ar*, m_r*, m_aw*, m_w*, m_b*  out/in  standard AXI4 master port.
- id = ID_W bits, len 8, size 3, burst 2.
- Same widths and signal set as the core's io_master_* bus.

Behaviour:
Reset:
- All valid/ready outputs = 0, both FSMs idle.
- Round-robin pointers rr_rd = rr_wr = 0.
- m_arburst / m_awburst are constant 2'b01 (INCR).

Read FSM: RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE.
- RD_IDLE:
  - Pick the first requester with ar_valid, searching from rr_rd upward with wrap.
  - Latch its index g_rd plus addr/len/size into registers; go to RD_ADDR.
  - Assert req_ar_ready_o[g_rd] in the same cycle (one-cycle accept).
  - rr_rd <= g_rd+1, wrapping at NUM_REQ.
- RD_ADDR:
  - m_arvalid = 1 with the latched fields; m_arid = g_rd zero-extended.
  - m_arvalid is held until m_arready; then go to RD_DATA.
- RD_DATA:
  - m_rready = req_r_ready_i[g_rd]; req_r_valid_o[g_rd] = m_rvalid; other requesters' r_valid = 0.
  - Data, resp and last pass through combinationally.
  - On m_rvalid & m_rready & m_rlast, go to RD_IDLE.
- Minimum latency: 1 cycle from req_ar_valid to m_arvalid.

Write FSM: WR_IDLE -> WR_XFER -> WR_RESP -> WR_IDLE.
- WR_IDLE: grant on req_aw_valid using rr_wr, same rules as the read side.
- WR_XFER:
  - AW and W run independently.
  - aw_done is set on m_awvalid & m_awready; m_awvalid = !aw_done.
  - W beats pass through from g_wr: m_wvalid = req_w_valid_i[g_wr] & !w_done; req_w_ready_o[g_wr] = m_wready & !w_done.
  - w_done is set on a handshake with wlast.
  - When aw_done and w_done are both set (including the same cycle), go to WR_RESP.
- WR_RESP:
  - m_bready / req_b_valid_o[g_wr] are routed the same way as the R channel.
  - On the b handshake, go to WR_IDLE and clear the done flags.

Boundary conditions:
- Read and write grants may target the same requester concurrently; no ordering between directions is guaranteed.
- A requester that deasserts valid before being granted is never granted.
- With a single requester active, it is granted on every idle cycle.
- Reset asserted mid-burst aborts both FSMs immediately; downstream state is the system's responsibility.
- len = 0 is a single-beat transfer; len = 255 must be passed intact.

Optional Feature:
Macro: AXI_ARB_IDCHK_EN.
- Defined: m_rid / m_bid are compared with the granted index (zero-extended). On mismatch, the forwarded resp is forced to 2'b10 (SLVERR); data and last are unchanged.
- Undefined: IDs are ignored and resp passes through unmodified.

Decomposition:
- Shared package/define file holds:
  - FSM state encodings (RD_*, WR_*).
  - AXI burst constant INCR = 2'b01.
  - Resp constants OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
- One sub-module: ysyx_23060025_rr_pick. It is combinational: takes a request vector and pointer, returns found + index. It is instantiated twice.

Test Plan:
1. NUM_REQ=3; requesters 0, 1, 2 issue single reads continuously -> grant order 0,1,2,0; each m_arid equals its index.
2. Requester 1 reads at 0x8000_0000 with len=3; slave returns 4 beats, the last with rlast -> all 4 beats reach requester 1 only; FSM returns to idle after beat 4.
3. Write with AW accepted 3 cycles before W, then a repeat with W first -> exactly one B forwarded in each case; the write completes in both orders.
4. Concurrent read from requester 0 and write from requester 2 -> both transactions proceed in parallel; neither channel is stalled by the other.
5. Reset pulsed during RD_DATA beat 2 of 4 -> next cycle all outputs are 0, rr_rd = 0, and a new request is granted normally.
6. With AXI_ARB_IDCHK_EN, slave returns rid=3 while g_rd=1 with rresp=00 -> req_r_resp_o = 2'b10. Without the macro -> 2'b00.
